// File: rtl/huffman_dec_controller.sv
// huffman_dec_controller: JPEG Huffman block decoder control, one bit per handshake, external code LUT.
// Define HUFFDEC_DC_PRED_EN to add the DC predictor to coefficient 0.
module huffman_dec_controller #(
    parameter int MAX_CODE_LEN = 16,
    parameter int COEF_W = 10
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   is_luminance,
    input  logic                   Huffman_dec_start,
    input  logic                   bit_valid,
    input  logic                   bit_in,
    output logic                   bit_ready,
    output logic [15:0]            lut_code,
    output logic [4:0]             lut_code_len,
    output logic                   lut_is_dc,
    output logic                   lut_is_luma,
    input  logic                   lut_hit,
    input  logic [3:0]             lut_run,
    input  logic [3:0]             lut_size,
    output logic                   Huffmandec_active,
    output logic [64*COEF_W-1:0]   zigzag_pix_out,
    output logic                   block_valid,
    output logic                   block_error
);
    localparam int MW = COEF_W - 1;
    localparam logic [3:0] MAX_SIZE = 4'(COEF_W - 1);
    localparam logic [4:0] MAX_LEN = 5'(MAX_CODE_LEN);
    localparam logic [COEF_W:0] ONE = 1;

    typedef enum logic [2:0] {IDLE, DC_CODE, DC_MAG, AC_CODE, AC_MAG, FILL, DONE, ERR} state_t;

    state_t state, state_n;
    logic [15:0] code;
    logic [4:0] len;
    logic [6:0] k, k_run, k_zrl;
    logic [3:0] size, cnt, cnt_n;
    logic [MW-1:0] mag, mag_n;
    logic luma, is_code, is_mag, hit, xfer, mag_done, eob, zrl;
    logic [COEF_W:0] diff;
    logic [COEF_W-1:0] val, coef0;

    assign is_code = state == DC_CODE || state == AC_CODE;
    assign is_mag = state == DC_MAG || state == AC_MAG;
    assign hit = is_code && len != 5'd0 && lut_hit;
    assign bit_ready = is_code ? !hit && len != MAX_LEN : is_mag && cnt < size;
    assign xfer = bit_valid && bit_ready;
    assign mag_n = xfer ? {mag[MW-2:0], bit_in} : mag;
    assign cnt_n = cnt + {3'b000, xfer};
    assign mag_done = is_mag && cnt_n == size;
    assign eob = lut_run == 4'd0 && lut_size == 4'd0;
    assign zrl = lut_run == 4'hF && lut_size == 4'd0;
    assign k_run = k + {3'b000, lut_run};
    assign k_zrl = k + 7'd16;
    // Negative values are sent as the ones' complement of their magnitude
    assign diff = {2'b00, mag_n} - ((ONE << size) - ONE);
    assign val = size == 4'd0 ? '0 : mag_n[size - 4'd1] ? COEF_W'(mag_n) : diff[COEF_W-1:0];

    assign lut_code = code;
    assign lut_code_len = len;
    assign lut_is_dc = state == DC_CODE;
    assign lut_is_luma = luma;
    assign Huffmandec_active = !(state inside {IDLE, DONE, ERR});
    assign block_valid = state == DONE;
    assign block_error = state == ERR;

`ifdef HUFFDEC_DC_PRED_EN
    logic [COEF_W-1:0] dc_pred;

    always_ff @(posedge clock)
        if (reset || (state == IDLE && Huffman_dec_start && is_luminance != luma))
            dc_pred <= '0;
        else if (state == DONE)
            dc_pred <= zigzag_pix_out[COEF_W-1:0];

    assign coef0 = dc_pred + val;
`else
    assign coef0 = val;
`endif

    always_ff @(posedge clock)
        state <= reset ? IDLE : state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (Huffman_dec_start) state_n = DC_CODE;
            DC_CODE, AC_CODE:
                if (hit)
                    state_n = lut_size > MAX_SIZE ? ERR :
                              state == DC_CODE ? DC_MAG :
                              eob ? FILL :
                              zrl ? (k_zrl > 7'd63 ? ERR : AC_CODE) :
                              k_run > 7'd63 ? ERR : AC_MAG;
                else if (len == MAX_LEN)
                    state_n = ERR;
            DC_MAG: if (mag_done) state_n = AC_CODE;
            AC_MAG: if (mag_done) state_n = k == 7'd63 ? DONE : AC_CODE;
            FILL: state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            code <= '0;
            len <= '0;
            k <= '0;
            size <= '0;
            cnt <= '0;
            mag <= '0;
            luma <= 1'b0;
            zigzag_pix_out <= '0;
        end else begin
            if (state == IDLE && Huffman_dec_start) begin
                luma <= is_luminance;
                code <= '0;
                len <= '0;
                k <= 7'd1;
                zigzag_pix_out <= '0;
            end
            if (hit) begin
                size <= lut_size;
                code <= '0;
                len <= '0;
                cnt <= '0;
                mag <= '0;
                if (state == AC_CODE) k <= zrl ? k_zrl : k_run;
            end else if (is_code && xfer) begin
                code <= {code[14:0], bit_in};
                len <= len + 5'd1;
            end
            if (is_mag) begin
                mag <= mag_n;
                cnt <= cnt_n;
            end
            if (mag_done) begin
                if (state == DC_MAG)
                    zigzag_pix_out[COEF_W-1:0] <= coef0;
                else begin
                    zigzag_pix_out[COEF_W*k[5:0] +: COEF_W] <= val;
                    k <= k + 7'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_huffman_dec_controller.sv
// tb_huffman_dec_controller: symbol-level encoder + block model against the decoder, with a stand-in luma code table.
module tb_huffman_dec_controller;
    localparam int NT = 22;
    localparam bit T_DC [NT] = '{1,1,1,1,1,1,1,1,1,1,1, 0,0,0,0,0,0,0,0,0,0,0};
    localparam logic [15:0] T_CODE [NT] = '{16'h0000, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006,
        16'h000E, 16'h001E, 16'h003E, 16'h007E, 16'h00FE, 16'h0000, 16'h0001, 16'h0004, 16'h000A,
        16'h000B, 16'h000C, 16'h001A, 16'h001B, 16'h001C, 16'h003A, 16'h07F9};
    localparam int T_LEN [NT] = '{2,3,3,3,3,3,4,5,6,7,8, 2,2,3,4,4,4,5,5,5,6,11};
    localparam int T_RUN [NT] = '{0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,1,0,1,2,3,15};
    localparam int T_SIZE [NT] = '{0,1,2,3,4,5,6,7,8,9,10, 1,2,3,0,4,1,5,2,1,1,0};

    logic clock = 0, reset = 1, is_luminance = 0, Huffman_dec_start = 0, bit_valid = 0, bit_in = 0;
    logic bit_ready, lut_is_dc, lut_is_luma, lut_hit, Huffmandec_active, block_valid, block_error;
    logic [15:0] lut_code;
    logic [4:0] lut_code_len;
    logic [3:0] lut_run, lut_size;
    logic [639:0] zigzag_pix_out;

    huffman_dec_controller dut (
        .clock(clock), .reset(reset), .is_luminance(is_luminance), .Huffman_dec_start(Huffman_dec_start),
        .bit_valid(bit_valid), .bit_in(bit_in), .bit_ready(bit_ready), .lut_code(lut_code),
        .lut_code_len(lut_code_len), .lut_is_dc(lut_is_dc), .lut_is_luma(lut_is_luma), .lut_hit(lut_hit),
        .lut_run(lut_run), .lut_size(lut_size), .Huffmandec_active(Huffmandec_active),
        .zigzag_pix_out(zigzag_pix_out), .block_valid(block_valid), .block_error(block_error)
    );

    always #5 clock = ~clock;

    always_comb begin
        lut_hit = 1'b0;
        lut_run = 4'd0;
        lut_size = 4'd0;
        for (int i = 0; i < NT; i++)
            if (T_DC[i] == lut_is_dc && 5'(T_LEN[i]) == lut_code_len && T_CODE[i] == lut_code) begin
                lut_hit = 1'b1;
                lut_run = 4'(T_RUN[i]);
                lut_size = 4'(T_SIZE[i]);
            end
    end

    bit q[$];
    logic [9:0] m_coef [64];
    logic [9:0] m_pred = '0;
    logic [639:0] exp_zig = '0;
    int m_k, vectors = 0, miscompares = 0;
    bit m_err, m_stop, m_prev_luma = 0, exp_err = 0, exp_luma = 0, busy = 0, chk_en = 0;

    task automatic chk(input string name, input logic [639:0] act, input logic [639:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic put_sym(input bit dc, input int r, input int s);
        int idx = -1;
        logic [15:0] c;
        for (int i = 0; i < NT; i++)
            if (T_DC[i] == dc && T_RUN[i] == r && T_SIZE[i] == s) idx = i;
        if (idx < 0) $fatal(1, "FAIL table: no code for dc=%0d run=%0d size=%0d", dc, r, s);
        c = T_CODE[idx];
        for (int b = T_LEN[idx] - 1; b >= 0; b--) q.push_back(c[b]);
    endtask

    task automatic put_mag(input int s, input int v);
        logic [31:0] m = v > 0 ? v : v + (1 << s) - 1;
        for (int b = s - 1; b >= 0; b--) q.push_back(m[b]);
    endtask

    task automatic begin_block(input bit luma);
        q.delete();
        for (int i = 0; i < 64; i++) m_coef[i] = '0;
        m_k = 1;
        m_err = 0;
        m_stop = 0;
        exp_luma = luma;
        if (luma != m_prev_luma) m_pred = '0;
        m_prev_luma = luma;
    endtask

    task automatic dc_sym(input int s, input int v);
        put_sym(1, 0, s);
        put_mag(s, v);
        m_coef[0] = m_pred + 10'(v);
    endtask

    task automatic ac_sym(input int r, input int s, input int v);
        put_sym(0, r, s);
        put_mag(s, v);
        if (!m_stop) begin
            m_k += r;
            if (m_k > 63) begin
                m_err = 1;
                m_stop = 1;
            end else begin
                m_coef[m_k] = 10'(v);
                m_k++;
                if (m_k == 64) m_stop = 1;
            end
        end
    endtask

    task automatic eob();
        put_sym(0, 0, 0);
        m_stop = 1;
    endtask

    task automatic zrl();
        put_sym(0, 15, 0);
        if (!m_stop) begin
            m_k += 16;
            if (m_k > 63) begin
                m_err = 1;
                m_stop = 1;
            end
        end
    endtask

    task automatic do_reset();
        bit_valid = 0;
        Huffman_dec_start = 0;
        reset = 1;
        @(posedge clock);
        #1;
        reset = 0;
        busy = 0;
        m_pred = '0;
        m_prev_luma = 0;
    endtask

    task automatic run_block(input int stall_start, input int stall_len, input int abort_at);
        int idx = 0;
        bit done = 0, stall;
        exp_err = m_err;
        for (int i = 0; i < 64; i++) exp_zig[i*10 +: 10] = m_coef[i];
        is_luminance = exp_luma;
        Huffman_dec_start = 1;
        @(posedge clock);
        #1;
        Huffman_dec_start = 0;
        busy = 1;
        for (int cyc = 1; cyc <= 4000 && !done; cyc++) begin
            if (cyc == abort_at) begin
                do_reset();
                return;
            end
            stall = cyc >= stall_start && cyc < stall_start + stall_len;
            bit_valid = !stall && idx < q.size();
            bit_in = bit_valid ? q[idx] : 1'b0;
            #1;
            if (bit_valid && bit_ready) idx++;
            @(posedge clock);
            #1;
            done = block_valid || block_error;
        end
        bit_valid = 0;
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout: no block_valid/block_error within 4000 cycles");
        end
        chk("bits_used", idx, q.size());
`ifdef HUFFDEC_DC_PRED_EN
        if (!m_err) m_pred = m_coef[0];
`endif
        @(posedge clock);
        #1;
        busy = 0;
    endtask

    always @(negedge clock)
        if (chk_en) begin
            if (busy) begin
                if (block_valid || block_error) begin
                    chk("active_at_end", Huffmandec_active, 0);
                    chk("block_valid", block_valid, !exp_err);
                    chk("block_error", block_error, exp_err);
                    chk("zigzag", zigzag_pix_out, exp_zig);
                end else begin
                    chk("active", Huffmandec_active, 1);
                    chk("luma_sel", lut_is_luma, exp_luma);
                end
            end else begin
                chk("idle_active", Huffmandec_active, 0);
                chk("idle_pulse", {block_valid, block_error}, 0);
                chk("idle_ready", bit_ready, 0);
            end
        end

    initial begin
        repeat (2) @(posedge clock);
        #1;
        reset = 0;
        chk("rst_ready", bit_ready, 0);
        chk("rst_valid", block_valid, 0);
        chk("rst_error", block_error, 0);
        chk("rst_active", Huffmandec_active, 0);
        chk("rst_code", lut_code, 0);
        chk("rst_len", lut_code_len, 0);
        chk("rst_isdc", lut_is_dc, 0);
        chk("rst_luma", lut_is_luma, 0);
        chk("rst_zigzag", zigzag_pix_out, 0);
        chk_en = 1;

        begin_block(1); dc_sym(0, 0); eob(); run_block(0, 0, 0);
        chk("pin_empty", zigzag_pix_out, 0);

        do_reset(); begin_block(1); dc_sym(3, 5); eob(); run_block(0, 0, 0);
        chk("pin_dc_pos", zigzag_pix_out[9:0], 10'h005);

        do_reset(); begin_block(1); dc_sym(3, -5); eob(); run_block(0, 0, 0);
        chk("pin_dc_neg", zigzag_pix_out[9:0], 10'h3FB);

        do_reset(); begin_block(1); dc_sym(0, 0); ac_sym(0, 1, 1); zrl(); ac_sym(0, 1, -1); eob();
        run_block(0, 0, 0);
        chk("pin_ac_c1", zigzag_pix_out[19:10], 10'h001);
        chk("pin_ac_c18", zigzag_pix_out[189:180], 10'h3FF);

        begin_block(1); dc_sym(0, 0); ac_sym(0, 1, 1); zrl(); ac_sym(0, 1, -1); eob();
        run_block(6, 5, 0);

        begin_block(1); dc_sym(0, 0);
        repeat (63) ac_sym(0, 1, 1);
        run_block(0, 0, 0);
        chk("pin_full_c63", zigzag_pix_out[639:630], 10'h001);

        begin_block(1); repeat (16) q.push_back(1'b1); m_err = 1; m_stop = 1; run_block(0, 0, 0);

        begin_block(1); put_sym(1, 0, 10); m_err = 1; m_stop = 1; run_block(0, 0, 0);

        begin_block(0); dc_sym(2, 3); repeat (4) zrl(); run_block(0, 0, 0);

        begin_block(0); dc_sym(4, -9); ac_sym(1, 1, -1); ac_sym(0, 5, 20); ac_sym(2, 1, 1);
        ac_sym(3, 1, -1); ac_sym(1, 2, -3); ac_sym(0, 3, -7); ac_sym(0, 4, 12); eob();
        run_block(0, 0, 0);
        chk("pin_mix_c3", zigzag_pix_out[39:30], 10'h014);

        begin_block(1); dc_sym(3, 5); eob(); run_block(0, 0, 4);
        chk("abort_active", Huffmandec_active, 0);
        begin_block(1); dc_sym(3, 5); eob(); run_block(0, 0, 0);
        chk("pin_after_abort", zigzag_pix_out[9:0], 10'h005);

`ifdef HUFFDEC_DC_PRED_EN
        do_reset(); begin_block(1); dc_sym(3, 5); eob(); run_block(0, 0, 0);
        chk("pin_pred_1", zigzag_pix_out[9:0], 10'h005);
        begin_block(1); dc_sym(2, 3); eob(); run_block(0, 0, 0);
        chk("pin_pred_2", zigzag_pix_out[9:0], 10'h008);
        do_reset(); begin_block(1); dc_sym(2, 3); eob(); run_block(0, 0, 0);
        chk("pin_pred_rst", zigzag_pix_out[9:0], 10'h003);
`endif

        repeat (2) @(posedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
